// File: rtl/z80_io_if.sv
// z80_io_if
// Bundles the request side and the Z80 I/O bus side of z80_io_master.
//   Request side : req, we, addr, wdata (to master); busy, done, rdata (from master)
//   Z80 bus side : bus_a, bus_d_out, bus_d_oe, n_iorq, n_rd, n_wr, n_m1 (from master);
//                  bus_d_in, n_wait (to master)
// Modport master is the cycle initiator.
// Modport slave is whatever drives requests and answers on the bus, such as a bench or a port model.
interface z80_io_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        n_wait;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        n_iorq;
  logic        n_rd;
  logic        n_wr;
  logic        n_m1;

  modport master (
    input  req, we, addr, wdata, n_wait, bus_d_in,
    output busy, done, rdata, bus_a, bus_d_out, bus_d_oe, n_iorq, n_rd, n_wr, n_m1
  );

  modport slave (
    output req, we, addr, wdata, n_wait, bus_d_in,
    input  busy, done, rdata, bus_a, bus_d_out, bus_d_oe, n_iorq, n_rd, n_wr, n_m1
  );
endinterface

// File: rtl/z80_io_master.sv
// z80_io_master
// Turns single-word read/write requests into Z80 I/O bus cycles of the form
// T1, T2, TW, (TW)*, T3.
// Every T-state lasts T_DIV clk cycles.
// It only ever generates I/O cycles, so n_m1 is held high.
// Ports:
//   clk   : system clock
//   n_rst : asynchronous, active-low reset
//   io    : z80_io_if.master, which carries the request handshake and the Z80 I/O bus
// Parameter:
//   T_DIV : clk cycles per T-state (even, >= 2)
module z80_io_master #(
  parameter int T_DIV = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  z80_io_if.master       io
);

  localparam int HALF = T_DIV / 2;
  localparam int CW   = (T_DIV > 2) ? $clog2(T_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept;
  logic          last_clk;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          we_q;
  logic [7:0]    rdata_q;
  logic          strobe;

  assign last_clk = (cnt == CW'(T_DIV - 1));

  // State and T-state sub-counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic.
  // Each non-IDLE state runs its counter through 0..T_DIV-1.
  // n_wait is only sampled on the last clk of a TW.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (state == IDLE) begin
      cnt_n = '0;
      if (io.req) begin
        state_n = T1;
        accept  = 1'b1;
      end
    end else if (!last_clk) begin
      cnt_n = cnt + CW'(1);
    end else begin
      cnt_n = '0;
      case (state)
        T1:      state_n = T2;
        T2:      state_n = TW;
        TW:      state_n = io.n_wait ? T3 : TW;
        T3:      state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Request fields are latched only on acceptance.
  // A req that arrives while busy therefore cannot disturb a cycle already in flight.
  // Read data is captured on the last clk before the strobes release.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= io.addr;
        wdata_q <= io.wdata;
        we_q    <= io.we;
      end
      if (state == T3 && cnt == CW'(HALF - 1) && !we_q) begin
        rdata_q <= io.bus_d_in;
      end
    end
  end

  // Bus outputs are decoded from state and counter.
  // Because of that, an asynchronous reset releases the strobes at once.
  // The strobes cover T2, every TW and the first half of T3.
  // n_rd and n_wr are both gated by the same strobe term.
  // So neither can go low unless n_iorq is also low.
  always_comb begin
    strobe       = (state == T2) || (state == TW) ||
                   (state == T3 && cnt < CW'(HALF));
    io.busy      = (state != IDLE);
    io.done      = (state == T3) && last_clk;
    io.rdata     = rdata_q;
    io.bus_a     = addr_q;
    io.bus_d_out = wdata_q;
    io.bus_d_oe  = we_q && (state != IDLE);
    io.n_iorq    = !strobe;
    io.n_rd      = !(strobe && !we_q);
    io.n_wr      = !(strobe && we_q);
    io.n_m1      = 1'b1;
  end

endmodule

// File: tb/tb_z80_io_master.sv
// tb_z80_io_master
// Directed bench for z80_io_master with T_DIV=4.
// Clk k is numbered from the acceptance edge: clk 1 is the first T1 clk.
// Every output is checked mid-cycle against a hand-derived timeline.
module tb_z80_io_master;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  logic [7:0] rdata_hold;

  z80_io_if io_bus ();

  z80_io_master #(.T_DIV(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .io    (io_bus)
  );

  // Free-running clock: posedge at 5, 15, ...; outputs are sampled on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Must be called at a negedge in IDLE.
  // Issues one request and walks the resulting cycle clk by clk.
  // n_extra       : number of extra TWs (n_wait is held low for that many samples)
  // abort_at      : clk index at which n_rst is pulsed (0 = never)
  // poke          : re-pulse req with a different addr during T2
  // Returns at the negedge of the IDLE clk after done, ready for a back-to-back request.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] d,
                               input int n_extra, input logic [7:0] din,
                               input int abort_at, input logic poke);
    int  total;
    logic strobe_exp;
    total = 16 + 4 * n_extra;
    io_bus.req      = 1'b1;
    io_bus.we       = w;
    io_bus.addr     = a;
    io_bus.wdata    = d;
    io_bus.n_wait   = 1'b1;
    io_bus.bus_d_in = din;
    @(posedge clk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        io_bus.req   = 1'b0;
        io_bus.addr  = ~a;
        io_bus.wdata = ~d;
        io_bus.we    = ~w;
      end
      if (poke && k == 6) begin
        io_bus.req  = 1'b1;
        io_bus.addr = 16'h1234;
      end
      if (poke && k == 7) io_bus.req = 1'b0;
      io_bus.n_wait = (k >= 9 && k <= 8 + 4 * n_extra) ? 1'b0 : 1'b1;

      if (k == abort_at) begin
        n_rst = 1'b0;
        #1;
        checkOutput("rst_n_iorq", io_bus.n_iorq, 1);
        checkOutput("rst_n_wr", io_bus.n_wr, 1);
        checkOutput("rst_oe", io_bus.bus_d_oe, 0);
        checkOutput("rst_busy", io_bus.busy, 0);
        checkOutput("rst_done", io_bus.done, 0);
        checkOutput("rst_bus_a", io_bus.bus_a, 0);
        checkOutput("rst_rdata", io_bus.rdata, 0);
        rdata_hold = 8'h00;
        io_bus.n_wait = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          checkOutput("post_rst_done", io_bus.done, 0);
          checkOutput("post_rst_busy", io_bus.busy, 0);
        end
        return;
      end

      strobe_exp = (k >= 5) && (k <= total - 2);
      checkOutput("busy", io_bus.busy, (k <= total) ? 1 : 0);
      checkOutput("done", io_bus.done, (k == total) ? 1 : 0);
      checkOutput("bus_a", io_bus.bus_a, a);
      checkOutput("n_m1", io_bus.n_m1, 1);
      checkOutput("n_iorq", io_bus.n_iorq, !strobe_exp);
      checkOutput("n_rd", io_bus.n_rd, !(strobe_exp && !w));
      checkOutput("n_wr", io_bus.n_wr, !(strobe_exp && w));
      checkOutput("bus_d_oe", io_bus.bus_d_oe, (w && k <= total) ? 1 : 0);
      if (w) checkOutput("bus_d_out", io_bus.bus_d_out, d);
      if (w || k < total - 1) checkOutput("rdata_hold", io_bus.rdata, rdata_hold);
      if (!w && k == total) begin
        checkOutput("rdata", io_bus.rdata, din);
        rdata_hold = din;
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rdata_hold = 8'h00;
    n_rst           = 1'b0;
    io_bus.req      = 1'b0;
    io_bus.we       = 1'b0;
    io_bus.addr     = 16'h0000;
    io_bus.wdata    = 8'h00;
    io_bus.n_wait   = 1'b1;
    io_bus.bus_d_in = 8'h00;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", io_bus.busy, 0);
    checkOutput("reset_done", io_bus.done, 0);
    checkOutput("reset_n_iorq", io_bus.n_iorq, 1);
    checkOutput("reset_n_rd", io_bus.n_rd, 1);
    checkOutput("reset_n_wr", io_bus.n_wr, 1);
    checkOutput("reset_n_m1", io_bus.n_m1, 1);
    checkOutput("reset_bus_a", io_bus.bus_a, 0);
    checkOutput("reset_bus_d_out", io_bus.bus_d_out, 0);
    checkOutput("reset_oe", io_bus.bus_d_oe, 0);
    checkOutput("reset_rdata", io_bus.rdata, 0);
    n_rst = 1'b1;
    @(negedge clk);

    $display("[TB] write FFFD/07");
    applyStimulus(1'b1, 16'hFFFD, 8'h07, 0, 8'h00, 0, 1'b0);
    $display("[TB] read 00CF");
    applyStimulus(1'b0, 16'h00CF, 8'h00, 0, 8'h5A, 0, 1'b0);
    $display("[TB] write 00FB with 3 extra TW");
    applyStimulus(1'b1, 16'h00FB, 8'h80, 3, 8'h00, 0, 1'b0);
    $display("[TB] back-to-back writes FFFD/0E, BFFD/3F");
    applyStimulus(1'b1, 16'hFFFD, 8'h0E, 0, 8'h00, 0, 1'b0);
    applyStimulus(1'b1, 16'hBFFD, 8'h3F, 0, 8'h00, 0, 1'b0);
    $display("[TB] reset during TW");
    applyStimulus(1'b1, 16'h1234, 8'h55, 0, 8'h00, 10, 1'b0);
    applyStimulus(1'b1, 16'hFFFD, 8'h01, 0, 8'h00, 0, 1'b0);
    $display("[TB] req during T2 ignored");
    applyStimulus(1'b0, 16'h00FE, 8'h00, 0, 8'hA5, 0, 1'b1);
    applyStimulus(1'b0, 16'hBFFD, 8'h00, 1, 8'h3C, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
